// File: rtl/clk_div_monitor_pkg.sv
// Shared definitions for the divided-clock monitor: FSM state encoding,
// default ratio width and the saturating-limit helper.
package clk_div_monitor_pkg;

    localparam int DEF_RATIO_WD = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACQ  = 2'd1,
        ST_MEAS = 2'd2
    } mon_state_e;

    function automatic int unsigned sat_max(input int unsigned wd);
        return (32'd1 << wd) - 32'd1;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous bit, with asynchronous
// active-low reset. Also used on UART RX input paths.
module bit_sync (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/clk_div_monitor.sv
// Samples a divided clock in the reference domain, measures its period and
// high time, and reports match/lock, mismatch and dead-clock timeout status.
module clk_div_monitor
    import clk_div_monitor_pkg::*;
#(
    parameter int RATIO_WD    = DEF_RATIO_WD,
    parameter int LOCK_CNT    = 4,
    parameter int TIMEOUT_CYC = 512
) (
    input  logic                i_ref_clk,
    input  logic                i_rst_n,
    input  logic                i_mon_clk,
    input  logic                i_mon_en,
    input  logic [RATIO_WD-1:0] i_exp_ratio,
    output logic [RATIO_WD-1:0] o_meas_ratio,
    output logic [RATIO_WD-1:0] o_high_cnt,
    output logic                o_meas_vld,
    output logic                o_mismatch,
    output logic                o_locked,
    output logic                o_timeout
);

    localparam int TO_WD    = $clog2(TIMEOUT_CYC + 1);
    localparam int MATCH_WD = $clog2(LOCK_CNT + 1);

    localparam logic [RATIO_WD-1:0] SAT_MAX   = RATIO_WD'(sat_max(RATIO_WD));
    localparam logic [RATIO_WD-1:0] ONE_R     = RATIO_WD'(1);
    localparam logic [TO_WD-1:0]    TO_MAX    = TO_WD'(TIMEOUT_CYC);
    localparam logic [TO_WD-1:0]    TO_LAST   = TO_WD'(TIMEOUT_CYC - 1);
    localparam logic [TO_WD-1:0]    TO_ONE    = TO_WD'(1);
    localparam logic [MATCH_WD-1:0] LOCK_MAX  = MATCH_WD'(LOCK_CNT);
    localparam logic [MATCH_WD-1:0] LOCK_PRE  = MATCH_WD'(LOCK_CNT - 1);
    localparam logic [MATCH_WD-1:0] MATCH_ONE = MATCH_WD'(1);

    mon_state_e          state;
    mon_state_e          state_nxt;
    logic                s2;
    logic                s3;
    logic                rise;
    logic [RATIO_WD-1:0] per_cnt;
    logic [RATIO_WD-1:0] hi_cnt;
    logic [TO_WD-1:0]    to_cnt;
    logic [MATCH_WD-1:0] match_cnt;
    logic [RATIO_WD-1:0] exp_reg;
    logic                exp_chg;
    logic                is_match;
    logic                counting;
    logic                timeout_hit;
    logic                meas_take;

    bit_sync u_sync (
        .clock   (i_ref_clk),
        .reset_n (i_rst_n),
        .d       (i_mon_clk),
        .q       (s2)
    );

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s3 <= 1'b0;
        end else begin
            s3 <= s2;
        end
    end

    assign rise     = s2 & ~s3;
    assign exp_chg  = (exp_reg != i_exp_ratio);
    // Ratios 0 and 1 cannot be produced by a measurable clock, so never match them.
    assign is_match = (per_cnt == exp_reg) && (exp_reg > ONE_R);

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        counting    = 1'b0;
        timeout_hit = 1'b0;
        meas_take   = 1'b0;
        case (state)
            ST_IDLE: begin
                state_nxt = ST_ACQ;
            end
            ST_ACQ: begin
                counting = 1'b1;
                if (rise) begin
                    state_nxt = ST_MEAS;
                end else if (to_cnt == TO_LAST) begin
                    timeout_hit = 1'b1;
                end
            end
            ST_MEAS: begin
                counting = 1'b1;
                if (rise) begin
                    meas_take = 1'b1;
                end else if (to_cnt == TO_LAST) begin
                    timeout_hit = 1'b1;
                    state_nxt   = ST_ACQ;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        // Dropping the enable abandons any partial period without reporting it.
        if (!i_mon_en) begin
            state_nxt   = ST_IDLE;
            counting    = 1'b0;
            timeout_hit = 1'b0;
            meas_take   = 1'b0;
        end
    end

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
            to_cnt  <= '0;
        end else if (!counting) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
            to_cnt  <= '0;
        end else if (rise) begin
            per_cnt <= ONE_R;
            hi_cnt  <= RATIO_WD'(s2);
            to_cnt  <= '0;
        end else begin
            if (per_cnt != SAT_MAX) begin
                per_cnt <= per_cnt + ONE_R;
            end
            if (s2 && (hi_cnt != SAT_MAX)) begin
                hi_cnt <= hi_cnt + ONE_R;
            end
            if (to_cnt != TO_MAX) begin
                to_cnt <= to_cnt + TO_ONE;
            end
        end
    end

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            exp_reg      <= '0;
            match_cnt    <= '0;
            o_meas_ratio <= '0;
            o_high_cnt   <= '0;
            o_meas_vld   <= 1'b0;
            o_mismatch   <= 1'b0;
            o_locked     <= 1'b0;
            o_timeout    <= 1'b0;
        end else begin
            exp_reg    <= i_exp_ratio;
            o_meas_vld <= 1'b0;
            o_mismatch <= 1'b0;
            if (!i_mon_en) begin
                match_cnt <= '0;
                o_locked  <= 1'b0;
                o_timeout <= 1'b0;
            end else begin
                if (timeout_hit) begin
                    o_timeout <= 1'b1;
                    o_locked  <= 1'b0;
                    match_cnt <= '0;
                end
                if (meas_take) begin
                    o_meas_ratio <= per_cnt;
                    o_high_cnt   <= hi_cnt;
                    o_meas_vld   <= 1'b1;
                    if (is_match) begin
                        if (match_cnt != LOCK_MAX) begin
                            match_cnt <= match_cnt + MATCH_ONE;
                        end
                        if (match_cnt >= LOCK_PRE) begin
                            o_locked <= 1'b1;
                        end
                    end else begin
                        o_mismatch <= 1'b1;
                        match_cnt  <= '0;
                        o_locked   <= 1'b0;
                    end
                end
                // A new expected ratio restarts lock acquisition silently.
                if (exp_chg) begin
                    match_cnt <= '0;
                    o_locked  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Randomized self-checking bench for clk_div_monitor against a timestamp-based
// reference model of the measured periods, lock, mismatch and timeout.
module tb_clk_div_monitor;

    localparam int RW   = 8;
    localparam int LOCK = 4;
    localparam int TMO  = 512;
    localparam int SAT  = 255;

    logic          ref_clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          mon_clk = 1'b0;
    logic          mon_en = 1'b0;
    logic [RW-1:0] exp_ratio = '0;
    logic [RW-1:0] meas_ratio;
    logic [RW-1:0] high_cnt;
    logic          meas_vld;
    logic          mismatch;
    logic          locked;
    logic          timeout;

    int n_checks = 0;
    int n_pass = 0;

    int gen_per = 0;
    int gen_high = 0;
    int gen_ph = 0;

    // Model: the monitor sees the driven clock two reference cycles late and
    // measures each period as the distance between consecutive rise timestamps.
    int        k = 0;
    int        pref[$];
    bit        view_q[$];
    int        last_rise;
    int        anchor;
    int        run;
    bit        en_prev;
    int        exp_reg;
    int        m_ratio;
    int        m_high;
    bit        m_vld;
    bit        m_mis;
    bit        m_tmo;

    clk_div_monitor #(
        .RATIO_WD    (RW),
        .LOCK_CNT    (LOCK),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .i_ref_clk    (ref_clk),
        .i_rst_n      (rst_n),
        .i_mon_clk    (mon_clk),
        .i_mon_en     (mon_en),
        .i_exp_ratio  (exp_ratio),
        .o_meas_ratio (meas_ratio),
        .o_high_cnt   (high_cnt),
        .o_meas_vld   (meas_vld),
        .o_mismatch   (mismatch),
        .o_locked     (locked),
        .o_timeout    (timeout)
    );

    always #5 ref_clk = ~ref_clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic modelReset();
        view_q    = '{1'b0, 1'b0, 1'b0};
        last_rise = -1;
        anchor    = 0;
        run       = 0;
        en_prev   = 1'b0;
        exp_reg   = 0;
        m_ratio   = 0;
        m_high    = 0;
        m_vld     = 1'b0;
        m_mis     = 1'b0;
        m_tmo     = 1'b0;
    endtask

    task automatic modelStep(input bit mon, input bit en, input int exp_v);
        bit s2;
        bit s3;
        bit rise;
        int per;
        int hi;
        s3    = view_q[0];
        s2    = view_q[1];
        rise  = s2 && !s3;
        m_vld = 1'b0;
        m_mis = 1'b0;
        if (!en) begin
            run       = 0;
            m_tmo     = 1'b0;
            last_rise = -1;
        end else if (!en_prev) begin
            anchor    = k;
            last_rise = -1;
        end else if (rise) begin
            if (last_rise >= 0) begin
                per     = k - last_rise;
                hi      = pref[k] - pref[last_rise];
                m_ratio = (per > SAT) ? SAT : per;
                m_high  = (hi > SAT) ? SAT : hi;
                m_vld   = 1'b1;
                if (m_ratio == exp_reg && exp_reg >= 2) begin
                    run++;
                end else begin
                    m_mis = 1'b1;
                    run   = 0;
                end
            end
            last_rise = k;
            anchor    = k;
        end else if (k - anchor == TMO) begin
            m_tmo     = 1'b1;
            run       = 0;
            last_rise = -1;
        end
        if (exp_v != exp_reg) begin
            run = 0;
        end
        exp_reg = exp_v;
        en_prev = en;
        pref.push_back(pref[k] + int'(s2));
        view_q.push_back(mon);
        void'(view_q.pop_front());
        k++;
    endtask

    task automatic compareAll();
        checkOutput("meas_ratio", meas_ratio, m_ratio);
        checkOutput("high_cnt", high_cnt, m_high);
        checkOutput("meas_vld", meas_vld, m_vld);
        checkOutput("mismatch", mismatch, m_mis);
        checkOutput("locked", locked, (run >= LOCK) ? 1 : 0);
        checkOutput("timeout", timeout, m_tmo);
    endtask

    task automatic setGen(input int per, input int high);
        gen_per  = per;
        gen_high = high;
        gen_ph   = 0;
    endtask

    task automatic applyStimulus(input int n_cyc, input bit en, input int exp_v);
        for (int i = 0; i < n_cyc; i++) begin
            @(negedge ref_clk);
            compareAll();
            mon_en    = en;
            exp_ratio = RW'(exp_v);
            if (gen_per == 0) begin
                mon_clk = 1'b0;
            end else begin
                mon_clk = (gen_ph < gen_high);
                gen_ph  = (gen_ph + 1) % gen_per;
            end
            modelStep(mon_clk, mon_en, exp_v);
        end
    endtask

    // Asserts reset between clock edges so the asynchronous clear is observable.
    task automatic doReset();
        @(negedge ref_clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_meas_ratio", meas_ratio, 0);
        checkOutput("rst_high_cnt", high_cnt, 0);
        checkOutput("rst_meas_vld", meas_vld, 0);
        checkOutput("rst_mismatch", mismatch, 0);
        checkOutput("rst_locked", locked, 0);
        checkOutput("rst_timeout", timeout, 0);
        modelReset();
        @(negedge ref_clk);
        @(negedge ref_clk);
        rst_n  = 1'b1;
        mon_en = 1'b0;
        modelStep(mon_clk, 1'b0, int'(exp_ratio));
    endtask

    initial begin
        int per;
        int high;
        int exp_v;
        int len;
        bit en;
        pref = '{0};
        modelReset();
        $display("[TB] starting clk_div_monitor bench");
        doReset();

        setGen(2, 1);   applyStimulus(60, 1'b1, 2);
        setGen(5, 2);   applyStimulus(80, 1'b1, 5);
        setGen(5, 3);   applyStimulus(60, 1'b1, 5);
        setGen(8, 4);   applyStimulus(100, 1'b1, 8);
        setGen(6, 3);   applyStimulus(60, 1'b1, 8);
        applyStimulus(60, 1'b1, 6);

        setGen(0, 0);   applyStimulus(TMO + 40, 1'b1, 6);
        applyStimulus(5, 1'b0, 6);

        setGen(300, 150); applyStimulus(1300, 1'b1, 8);
        applyStimulus(1300, 1'b1, 255);

        setGen(2, 1);   applyStimulus(40, 1'b1, 0);
        applyStimulus(40, 1'b1, 1);

        setGen(20, 10); applyStimulus(47, 1'b1, 20);
        applyStimulus(3, 1'b0, 20);
        applyStimulus(60, 1'b1, 20);

        setGen(6, 2);   applyStimulus(60, 1'b1, 6);
        doReset();
        applyStimulus(60, 1'b1, 6);

        for (int seg = 0; seg < 24; seg++) begin
            case ($urandom_range(0, 9))
                0:       per = 0;
                1:       per = $urandom_range(256, 320);
                default: per = $urandom_range(2, 20);
            endcase
            high  = (per == 0) ? 0 : $urandom_range(1, per - 1);
            exp_v = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : ((per > SAT) ? SAT : per);
            en    = ($urandom_range(0, 7) != 0);
            len   = (per == 0) ? $urandom_range(400, 600) : $urandom_range(30, 250);
            if (per > 20) begin
                len = 900;
            end
            setGen(per, high);
            applyStimulus(len, en, exp_v);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
